// File: rtl/bridge_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// bridge_buffer_ctrl
//   Control side of the west/north bridge buffer pair that sits between the
//   linear-projection producer and the systolic array. One tile at a time:
//   FILL (both sides written independently with a ready handshake), WAIT_SA
//   (hold until the array is ready), DRAIN (every stored word is read out
//   MODULES times, once per slice), FLUSH (let the read-latency pipeline
//   empty), then back to FILL with a one-cycle tile_done pulse.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   w_in_valid/w_in_ready   west producer handshake (ready only while filling)
//   n_in_valid/n_in_ready   north producer handshake
//   sa_ready                systolic array ready to start a drain
//   *_bank0_ena/wea/addra   buffer port A (write) controls per side
//   *_bank0_enb/addrb       buffer port B (read) controls per side
//   *_slicing_idx           slice select aligned with buffer dout
//   *_out_valid             buffer dout valid, RD_LATENCY after enb
//   tile_done               one-cycle pulse after the last valid beat
// ---------------------------------------------------------------------------

// One side (west or north) of the bridge: write counter with registered
// ready, read word/slice sequencer, and the read-latency alignment pipeline.
module bridge_side #(
  parameter int DEPTH      = 12,
  parameter int MODULES    = 4,
  parameter int AW         = 8,
  parameter int SW         = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fill,
  input  logic          drain,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ena,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic          enb,
  output logic [AW-1:0] addrb,
  output logic [SW-1:0] slicing_idx,
  output logic          out_valid,
  output logic          full_next,
  output logic          issue_done_next,
  output logic          pending
);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_WORD  = AW'(DEPTH - 1);
  localparam logic [SW-1:0] LAST_SLICE = SW'(MODULES - 1);
  // Every pipeline stage except the output one; the output stage may still
  // be presenting the final beat on the cycle we leave FLUSH.
  localparam logic [RD_LATENCY-1:0] PEND_MASK = {RD_LATENCY{1'b1}} >> 1;

  logic [AW:0]           wr_cnt_reg, wr_cnt_next;
  logic                  ready_reg;
  logic                  accept;
  logic [AW-1:0]         word_reg;
  logic [SW-1:0]         slice_reg;
  logic                  done_reg;
  logic                  issue;
  logic                  last_slice;
  logic [RD_LATENCY-1:0] v_pipe_reg;
  logic [SW-1:0]         s_pipe_reg [RD_LATENCY];

  // Write side. The counter is one bit wider than the address so that
  // "full" (count == DEPTH) is representable for any DEPTH.
  assign accept      = fill && in_valid && ready_reg;
  assign wr_cnt_next = clear ? '0 : wr_cnt_reg + {{AW{1'b0}}, accept};
  assign full_next   = (wr_cnt_next == DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      wr_cnt_reg <= wr_cnt_next;
      // Staying in FILL while this side still has room, or re-entering FILL.
      ready_reg  <= (fill && !full_next) || clear;
    end
  end

  assign in_ready = ready_reg;
  assign ena      = accept;
  assign wea      = accept;
  assign addra    = wr_cnt_reg[AW-1:0];

  // Read side: slice is the fast counter, word the slow one.
  assign issue           = drain && !done_reg;
  assign last_slice      = (slice_reg == LAST_SLICE);
  assign issue_done_next = done_reg || (issue && last_slice && (word_reg == LAST_WORD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg  <= '0;
      slice_reg <= '0;
      done_reg  <= 1'b0;
    end else if (clear) begin
      word_reg  <= '0;
      slice_reg <= '0;
      done_reg  <= 1'b0;
    end else if (issue) begin
      if (last_slice) begin
        slice_reg <= '0;
        if (word_reg == LAST_WORD) begin
          done_reg <= 1'b1;
        end else begin
          word_reg <= word_reg + 1'b1;
        end
      end else begin
        slice_reg <= slice_reg + 1'b1;
      end
    end
  end

  assign enb   = issue;
  assign addrb = word_reg;

  // Alignment pipeline. Slice stages only load on a valid beat, so the
  // output stage naturally holds the last issued slice between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe_reg <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        s_pipe_reg[i] <= '0;
      end
    end else begin
      v_pipe_reg[0] <= issue;
      if (issue) begin
        s_pipe_reg[0] <= slice_reg;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        v_pipe_reg[i] <= v_pipe_reg[i-1];
        if (v_pipe_reg[i-1]) begin
          s_pipe_reg[i] <= s_pipe_reg[i-1];
        end
      end
    end
  end

  assign out_valid   = v_pipe_reg[RD_LATENCY-1];
  assign slicing_idx = s_pipe_reg[RD_LATENCY-1];
  assign pending     = |(v_pipe_reg & PEND_MASK);
endmodule

module bridge_buffer_ctrl #(
  parameter int W_TOTAL_DEPTH   = 12,
  parameter int N_TOTAL_DEPTH   = 12,
  parameter int W_TOTAL_MODULES = 4,
  parameter int N_TOTAL_MODULES = 4,
  parameter int ADDR_WIDTH_W    = 8,
  parameter int ADDR_WIDTH_N    = 8,
  parameter int RD_LATENCY      = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               w_in_valid,
  output logic                               w_in_ready,
  input  logic                               n_in_valid,
  output logic                               n_in_ready,
  input  logic                               sa_ready,
  output logic                               w_bank0_ena,
  output logic                               w_bank0_wea,
  output logic [ADDR_WIDTH_W-1:0]            w_bank0_addra,
  output logic                               w_bank0_enb,
  output logic [ADDR_WIDTH_W-1:0]            w_bank0_addrb,
  output logic [$clog2(W_TOTAL_MODULES)-1:0] w_slicing_idx,
  output logic                               n_bank0_ena,
  output logic                               n_bank0_wea,
  output logic [ADDR_WIDTH_N-1:0]            n_bank0_addra,
  output logic                               n_bank0_enb,
  output logic [ADDR_WIDTH_N-1:0]            n_bank0_addrb,
  output logic [$clog2(N_TOTAL_MODULES)-1:0] n_slicing_idx,
  output logic                               w_out_valid,
  output logic                               n_out_valid,
  output logic                               tile_done
);
  typedef enum logic [1:0] {S_FILL, S_WAIT_SA, S_DRAIN, S_FLUSH} state_t;

  state_t state_reg, state_next;
  logic   fill, drain, clear;
  logic   tile_done_reg;
  logic   w_full_next, n_full_next;
  logic   w_issue_done_next, n_issue_done_next;
  logic   w_pending, n_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_FILL;
      tile_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // Pulses on the first FILL cycle of the next tile.
      tile_done_reg <= clear;
    end
  end

  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    case (state_reg)
      S_FILL:    if (w_full_next && n_full_next) state_next = S_WAIT_SA;
      S_WAIT_SA: if (sa_ready) state_next = S_DRAIN;
      S_DRAIN:   if (w_issue_done_next && n_issue_done_next) state_next = S_FLUSH;
      S_FLUSH: begin
        if (!w_pending && !n_pending) begin
          state_next = S_FILL;
          clear      = 1'b1;
        end
      end
      default:   state_next = S_FILL;
    endcase
  end

  assign fill      = (state_reg == S_FILL);
  assign drain     = (state_reg == S_DRAIN);
  assign tile_done = tile_done_reg;

  bridge_side #(
    .DEPTH      (W_TOTAL_DEPTH),
    .MODULES    (W_TOTAL_MODULES),
    .AW         (ADDR_WIDTH_W),
    .SW         ($clog2(W_TOTAL_MODULES)),
    .RD_LATENCY (RD_LATENCY)
  ) u_west (
    .clk             (clk),
    .rst_n           (rst_n),
    .fill            (fill),
    .drain           (drain),
    .clear           (clear),
    .in_valid        (w_in_valid),
    .in_ready        (w_in_ready),
    .ena             (w_bank0_ena),
    .wea             (w_bank0_wea),
    .addra           (w_bank0_addra),
    .enb             (w_bank0_enb),
    .addrb           (w_bank0_addrb),
    .slicing_idx     (w_slicing_idx),
    .out_valid       (w_out_valid),
    .full_next       (w_full_next),
    .issue_done_next (w_issue_done_next),
    .pending         (w_pending)
  );

  bridge_side #(
    .DEPTH      (N_TOTAL_DEPTH),
    .MODULES    (N_TOTAL_MODULES),
    .AW         (ADDR_WIDTH_N),
    .SW         ($clog2(N_TOTAL_MODULES)),
    .RD_LATENCY (RD_LATENCY)
  ) u_north (
    .clk             (clk),
    .rst_n           (rst_n),
    .fill            (fill),
    .drain           (drain),
    .clear           (clear),
    .in_valid        (n_in_valid),
    .in_ready        (n_in_ready),
    .ena             (n_bank0_ena),
    .wea             (n_bank0_wea),
    .addra           (n_bank0_addra),
    .enb             (n_bank0_enb),
    .addrb           (n_bank0_addrb),
    .slicing_idx     (n_slicing_idx),
    .out_valid       (n_out_valid),
    .full_next       (n_full_next),
    .issue_done_next (n_issue_done_next),
    .pending         (n_pending)
  );
endmodule

// File: tb/tb_bridge_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bridge_buffer_ctrl
//   Drives two instances from shared stimulus: A with the default 12x4/12x4
//   geometry, B with a 6-word, 2-slice north side. Each cycle, every output
//   of both instances is compared against a tile-level reference model:
//   words accepted in order while a side has room, drain beat k reads word
//   k/MODULES slice k%MODULES, and each issued beat reappears RD_LATENCY
//   cycles later as a scheduled out_valid event.
// ---------------------------------------------------------------------------
module tb_bridge_buffer_ctrl;
  localparam int RDL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic w_in_valid = 1'b0, n_in_valid = 1'b0, sa_ready = 1'b0;

  logic       a_w_ready, a_n_ready, a_w_ena, a_w_wea, a_w_enb, a_n_ena, a_n_wea, a_n_enb;
  logic       a_w_ov, a_n_ov, a_done;
  logic [7:0] a_w_addra, a_w_addrb, a_n_addra, a_n_addrb;
  logic [1:0] a_w_sidx, a_n_sidx;
  logic       b_w_ready, b_n_ready, b_w_ena, b_w_wea, b_w_enb, b_n_ena, b_n_wea, b_n_enb;
  logic       b_w_ov, b_n_ov, b_done;
  logic [7:0] b_w_addra, b_w_addrb, b_n_addra, b_n_addrb;
  logic [1:0] b_w_sidx;
  logic [0:0] b_n_sidx;

  bridge_buffer_ctrl #(.RD_LATENCY(RDL)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .w_in_valid(w_in_valid), .w_in_ready(a_w_ready),
    .n_in_valid(n_in_valid), .n_in_ready(a_n_ready), .sa_ready(sa_ready),
    .w_bank0_ena(a_w_ena), .w_bank0_wea(a_w_wea), .w_bank0_addra(a_w_addra),
    .w_bank0_enb(a_w_enb), .w_bank0_addrb(a_w_addrb), .w_slicing_idx(a_w_sidx),
    .n_bank0_ena(a_n_ena), .n_bank0_wea(a_n_wea), .n_bank0_addra(a_n_addra),
    .n_bank0_enb(a_n_enb), .n_bank0_addrb(a_n_addrb), .n_slicing_idx(a_n_sidx),
    .w_out_valid(a_w_ov), .n_out_valid(a_n_ov), .tile_done(a_done)
  );

  bridge_buffer_ctrl #(.N_TOTAL_DEPTH(6), .N_TOTAL_MODULES(2), .RD_LATENCY(RDL)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .w_in_valid(w_in_valid), .w_in_ready(b_w_ready),
    .n_in_valid(n_in_valid), .n_in_ready(b_n_ready), .sa_ready(sa_ready),
    .w_bank0_ena(b_w_ena), .w_bank0_wea(b_w_wea), .w_bank0_addra(b_w_addra),
    .w_bank0_enb(b_w_enb), .w_bank0_addrb(b_w_addrb), .w_slicing_idx(b_w_sidx),
    .n_bank0_ena(b_n_ena), .n_bank0_wea(b_n_wea), .n_bank0_addra(b_n_addra),
    .n_bank0_enb(b_n_enb), .n_bank0_addrb(b_n_addrb), .n_slicing_idx(b_n_sidx),
    .w_out_valid(b_w_ov), .n_out_valid(b_n_ov), .tile_done(b_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state, indexed [dut][side] with side 0 = west, 1 = north.
  int  depth [2][2];
  int  mods  [2][2];
  int  phase [2];          // 0 fill, 1 wait for array, 2 drain, 3 flush
  int  wr    [2][2];
  int  iss   [2][2];
  bit  rdy   [2][2];
  bit  td_exp[2];
  int  last_sl[2][2];
  bit  sched_v[2][2][16];  // out_valid events keyed by cycle modulo 16
  int  sched_s[2][2][16];
  int  obs_beats[2][2];
  int  tiles_seen[2];
  int  tiles_exp[2];

  logic [31:0] o_rdy[2], o_ena[2], o_wea[2], o_addra[2], o_enb[2], o_addrb[2];
  logic [31:0] o_ov[2], o_sidx[2];
  logic [31:0] o_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sample(input int d);
    if (d == 0) begin
      o_rdy[0] = {31'd0, a_w_ready}; o_rdy[1] = {31'd0, a_n_ready};
      o_ena[0] = {31'd0, a_w_ena};   o_ena[1] = {31'd0, a_n_ena};
      o_wea[0] = {31'd0, a_w_wea};   o_wea[1] = {31'd0, a_n_wea};
      o_enb[0] = {31'd0, a_w_enb};   o_enb[1] = {31'd0, a_n_enb};
      o_ov[0]  = {31'd0, a_w_ov};    o_ov[1]  = {31'd0, a_n_ov};
      o_addra[0] = {24'd0, a_w_addra}; o_addra[1] = {24'd0, a_n_addra};
      o_addrb[0] = {24'd0, a_w_addrb}; o_addrb[1] = {24'd0, a_n_addrb};
      o_sidx[0] = {30'd0, a_w_sidx};   o_sidx[1] = {30'd0, a_n_sidx};
      o_done = {31'd0, a_done};
    end else begin
      o_rdy[0] = {31'd0, b_w_ready}; o_rdy[1] = {31'd0, b_n_ready};
      o_ena[0] = {31'd0, b_w_ena};   o_ena[1] = {31'd0, b_n_ena};
      o_wea[0] = {31'd0, b_w_wea};   o_wea[1] = {31'd0, b_n_wea};
      o_enb[0] = {31'd0, b_w_enb};   o_enb[1] = {31'd0, b_n_enb};
      o_ov[0]  = {31'd0, b_w_ov};    o_ov[1]  = {31'd0, b_n_ov};
      o_addra[0] = {24'd0, b_w_addra}; o_addra[1] = {24'd0, b_n_addra};
      o_addrb[0] = {24'd0, b_w_addrb}; o_addrb[1] = {24'd0, b_n_addrb};
      o_sidx[0] = {30'd0, b_w_sidx};   o_sidx[1] = {31'd0, b_n_sidx};
      o_done = {31'd0, b_done};
    end
  endtask

  function automatic bit in_v(input int s);
    return (s == 0) ? w_in_valid : n_in_valid;
  endfunction

  // Compare this cycle's outputs against the model, then advance the model.
  task automatic model_cycle(input int d);
    bit    acc[2];
    bit    isn[2];
    bit    ov;
    bit    more;
    int    slot;
    string sn;
    sample(d);
    slot = cyc % 16;
    for (int s = 0; s < 2; s++) begin
      sn     = (s == 0) ? "w" : "n";
      acc[s] = (phase[d] == 0) && rdy[d][s] && in_v(s);
      isn[s] = (phase[d] == 2) && (iss[d][s] < depth[d][s] * mods[d][s]);
      chk($sformatf("dut%0d_%s_in_ready", d, sn), o_rdy[s], {31'd0, rdy[d][s]});
      chk($sformatf("dut%0d_%s_ena", d, sn), o_ena[s], {31'd0, acc[s]});
      chk($sformatf("dut%0d_%s_wea", d, sn), o_wea[s], {31'd0, acc[s]});
      if (acc[s]) chk($sformatf("dut%0d_%s_addra", d, sn), o_addra[s], wr[d][s]);
      chk($sformatf("dut%0d_%s_enb", d, sn), o_enb[s], {31'd0, isn[s]});
      if (isn[s]) chk($sformatf("dut%0d_%s_addrb", d, sn), o_addrb[s], iss[d][s] / mods[d][s]);
      ov = sched_v[d][s][slot];
      sched_v[d][s][slot] = 1'b0;
      if (ov) last_sl[d][s] = sched_s[d][s][slot];
      chk($sformatf("dut%0d_%s_out_valid", d, sn), o_ov[s], {31'd0, ov});
      chk($sformatf("dut%0d_%s_slicing_idx", d, sn), o_sidx[s], last_sl[d][s]);
      if (o_ov[s] === 32'd1) obs_beats[d][s]++;
    end
    chk($sformatf("dut%0d_tile_done", d), o_done, {31'd0, td_exp[d]});
    if (o_done === 32'd1) begin
      tiles_seen[d]++;
      $display("[TB] dut%0d tile %0d done at cycle %0d: west beats %0d, north beats %0d",
               d, tiles_seen[d], cyc, obs_beats[d][0], obs_beats[d][1]);
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("dut%0d_side%0d_beats_per_tile", d, s), obs_beats[d][s], depth[d][s] * mods[d][s]);
        obs_beats[d][s] = 0;
      end
    end

    td_exp[d] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (acc[s]) wr[d][s]++;
      if (isn[s]) begin
        sched_v[d][s][(cyc + RDL) % 16] = 1'b1;
        sched_s[d][s][(cyc + RDL) % 16] = iss[d][s] % mods[d][s];
        iss[d][s]++;
      end
    end
    case (phase[d])
      0: if (wr[d][0] == depth[d][0] && wr[d][1] == depth[d][1]) phase[d] = 1;
      1: if (sa_ready) phase[d] = 2;
      2: if (iss[d][0] == depth[d][0] * mods[d][0] && iss[d][1] == depth[d][1] * mods[d][1]) phase[d] = 3;
      default: begin
        more = 1'b0;
        for (int s = 0; s < 2; s++)
          for (int k = 0; k < 16; k++)
            if (sched_v[d][s][k]) more = 1'b1;
        if (!more) begin
          phase[d]  = 0;
          td_exp[d] = 1'b1;
          tiles_exp[d]++;
          for (int s = 0; s < 2; s++) begin
            wr[d][s]  = 0;
            iss[d][s] = 0;
          end
        end
      end
    endcase
    for (int s = 0; s < 2; s++) rdy[d][s] = (phase[d] == 0) && (wr[d][s] < depth[d][s]);
  endtask

  task automatic run_cycle(input bit w, input bit n, input bit sa);
    @(posedge clk);
    #1;
    w_in_valid = w;
    n_in_valid = n;
    sa_ready   = sa;
    #1;
    model_cycle(0);
    model_cycle(1);
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    w_in_valid = 1'b0;
    n_in_valid = 1'b0;
    sa_ready   = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      sample(d);
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("rst_dut%0d_s%0d_in_ready", d, s), o_rdy[s], 0);
        chk($sformatf("rst_dut%0d_s%0d_ena", d, s), o_ena[s], 0);
        chk($sformatf("rst_dut%0d_s%0d_wea", d, s), o_wea[s], 0);
        chk($sformatf("rst_dut%0d_s%0d_addra", d, s), o_addra[s], 0);
        chk($sformatf("rst_dut%0d_s%0d_enb", d, s), o_enb[s], 0);
        chk($sformatf("rst_dut%0d_s%0d_addrb", d, s), o_addrb[s], 0);
        chk($sformatf("rst_dut%0d_s%0d_out_valid", d, s), o_ov[s], 0);
        chk($sformatf("rst_dut%0d_s%0d_slicing_idx", d, s), o_sidx[s], 0);
      end
      chk($sformatf("rst_dut%0d_tile_done", d), o_done, 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      sample(d);
      chk($sformatf("rel_dut%0d_w_in_ready", d), o_rdy[0], 0);
      chk($sformatf("rel_dut%0d_n_in_ready", d), o_rdy[1], 0);
      phase[d]  = 0;
      td_exp[d] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        wr[d][s] = 0;
        iss[d][s] = 0;
        rdy[d][s] = 1'b1;        // latched by the first edge after release
        last_sl[d][s] = 0;
        obs_beats[d][s] = 0;
        for (int k = 0; k < 16; k++) sched_v[d][s][k] = 1'b0;
      end
    end
    $display("[TB] reset applied at cycle %0d", cyc);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      tiles_seen[d] = 0;
      tiles_exp[d]  = 0;
      for (int s = 0; s < 2; s++) begin
        depth[d][s] = 12;
        mods[d][s]  = 4;
      end
    end
    depth[1][1] = 6;
    mods[1][1]  = 2;

    do_reset();

    // Back-to-back words on both sides; extra valids after full are ignored.
    repeat (16) run_cycle(1'b1, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b1);
    // in_valid held high through most of the drain: no writes may occur.
    repeat (45) run_cycle(1'b1, 1'b1, 1'b0);
    repeat (15) run_cycle(1'b0, 1'b0, 1'b0);

    // West every cycle, north every other cycle.
    for (int i = 0; i < 30; i++) run_cycle(1'b1, (i % 2) == 0, 1'b0);
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1);
    repeat (56) run_cycle(1'b0, 1'b0, 1'b0);

    // Random producer and array-ready activity.
    for (int i = 0; i < 600; i++)
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);

    // Abort in the middle of a drain.
    do_reset();
    repeat (12) run_cycle(1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1);
    repeat (20) run_cycle(1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (20) run_cycle(1'b0, 1'b0, 1'b0);

    // Recovery: a complete tile after the abort.
    repeat (12) run_cycle(1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1);
    repeat (55) run_cycle(1'b0, 1'b0, 1'b0);

    for (int d = 0; d < 2; d++)
      chk($sformatf("dut%0d_tile_count", d), tiles_seen[d], tiles_exp[d]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bridge_buffer_ctrl.md
Name: bridge_buffer_ctrl

Overview:
Controller that drives the control side of the west/north bridge buffer pair between linear projection and the systolic array. It sequences the write phase: per-side write enables and addresses, with a ready handshake to the linear-projection producer. It then sequences the drain phase: per-side read enables, read addresses and slicing index, plus aligned valid strobes to the systolic array. It operates as a single-bank fill-then-drain controller with a done pulse per tile.

Parameters:
W_TOTAL_DEPTH, 12, west words written per tile (write addresses 0..W_TOTAL_DEPTH-1)
N_TOTAL_DEPTH, 12, north words written per tile
W_TOTAL_MODULES, 4, west slices read out per stored word
N_TOTAL_MODULES, 4, north slices read out per stored word
ADDR_WIDTH_W, 8, west address width
ADDR_WIDTH_N, 8, north address width
RD_LATENCY, 2, cycles from enb/addrb issue to buffer dout valid

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
w_in_valid  in  1  west producer word valid this cycle
w_in_ready  out  1  west side accepting (write phase, not full)
n_in_valid  in  1  north producer word valid
n_in_ready  out  1  north side accepting
sa_ready  in  1  systolic array ready to start a drain
w_bank0_ena, w_bank0_wea  out  1 each  west port-A enable/write
w_bank0_addra  out  ADDR_WIDTH_W  west write address
w_bank0_enb  out  1  west port-B read enable
w_bank0_addrb  out  ADDR_WIDTH_W  west read address
w_slicing_idx  out  $clog2(W_TOTAL_MODULES)  west slice select, aligned to dout
n_bank0_ena, n_bank0_wea, n_bank0_addra, n_bank0_enb, n_bank0_addrb, n_slicing_idx  out  north equivalents (ADDR_WIDTH_N, $clog2(N_TOTAL_MODULES))
w_out_valid  out  1  west buffer dout valid this cycle
n_out_valid  out  1  north buffer dout valid this cycle
tile_done  out  1  one-cycle pulse after last valid beat of both sides

Behaviour:
- Reset (async, rst_n=0): state FILL; all counters 0; all enables, valids, tile_done 0; addresses and slicing_idx 0; both in_ready 1 one cycle after reset release (0 during reset).
- FSM: FILL -> WAIT_SA -> DRAIN -> FLUSH -> FILL.
- FILL: per side independent. Accept a write when in_valid && in_ready. On accept, assert ena=wea=1 combinationally with addra = write count, then increment count. in_ready drops the cycle after the accept of word DEPTH-1 and stays 0 until the next FILL. Both sides full -> WAIT_SA.
- WAIT_SA: no enables. sa_ready=1 -> DRAIN next cycle.
- DRAIN: no backpressure once started. Each cycle, each unfinished side issues enb=1, addrb=word counter, with slice counter s. Issue order: s=0..MODULES-1 for word 0, then word 1, etc. A side issues exactly DEPTH*MODULES beats, then holds enb=0. Both sides finished issuing -> FLUSH.
- slicing_idx and out_valid are the issued s and enb delayed by exactly RD_LATENCY cycles. slicing_idx holds its last value when out_valid=0.
- FLUSH: wait until the delay pipelines are empty. tile_done=1 for one cycle, coincident with entering FILL. Counters are cleared and in_ready returns to 1 on that same cycle.
- Unequal sides: the shorter side's out_valid ends early; tile_done waits for the longer side.
- in_valid outside FILL, or after a side is full, is ignored (no write).
- rst_n low mid-tile: immediate abort, pipelines cleared, no tile_done.

Test Plan:
- Reset, then 12 consecutive w_in_valid and n_in_valid -> addra 0..11 each with ena=wea=1; in_ready=0 from cycle 13.
- West writes in cycles 1-12, north delayed with gaps (valid every other cycle) -> WAIT_SA entered only after the 12th north write; no extra writes.
- sa_ready asserted in WAIT_SA -> 48 enb beats per side, addrb sequence 0,0,0,0,1,...,11 with s 0,1,2,3 repeating; out_valid 48 cycles starting RD_LATENCY=2 after the first enb; tile_done exactly 1 cycle after the last out_valid.
- N_TOTAL_MODULES=2, N_TOTAL_DEPTH=6 -> north gives 12 out_valid beats, west 48; tile_done follows the west last beat only.
- rst_n pulsed low at drain beat 20 -> all outputs 0 asynchronously; after release in_ready=1, tile_done never pulses for the aborted tile.
- in_valid held high during DRAIN -> wea stays 0, addra unchanged.
